// File: rtl/lockable_rr_arbiter_pkg.sv
// Shared types and helpers for the lockable round-robin arbiter.
package lockable_rr_arbiter_pkg;

    localparam int unsigned MAX_N     = 64;
    localparam int unsigned MAX_IDX_W = 6;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned arb_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Binary index of a one-hot (or zero) vector; zero input yields index 0.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lockable_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface lockable_rr_arbiter_if
    import lockable_rr_arbiter_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = arb_idx_w(N)
);
    logic             mode_rr;
    logic [N-1:0]     req;
    logic [N-1:0]     req_last;
    logic             accept;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             locked;

    modport master (
        output mode_rr, req, req_last, accept,
        input  gnt, gnt_idx, gnt_valid, locked
    );

    modport slave (
        input  mode_rr, req, req_last, accept,
        output gnt, gnt_idx, gnt_valid, locked
    );
endinterface

// File: rtl/lockable_rr_arbiter_rr_pick.sv
// Circular first-set-bit picker: bits at or above start win, else lowest set bit.
module rr_pick
    import lockable_rr_arbiter_pkg::*;
#(
    parameter int unsigned N     = 10,
    parameter int unsigned IDX_W = arb_idx_w(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);
    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] cand;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (IDX_W'(i) >= start);
        end
    end

    // Two-pass pick collapses to one isolate-lowest-bit on the chosen candidate set.
    assign masked = vec & mask;
    assign cand   = (|masked) ? masked : vec;
    assign onehot = cand & (~cand + N'(1));
    assign idx    = IDX_W'(onehot_to_idx(MAX_N'(onehot)));

endmodule

// File: rtl/lockable_rr_arbiter.sv
// N-way arbiter, fixed-priority or round-robin, holding the grant across multi-beat transfers.
module lockable_rr_arbiter
    import lockable_rr_arbiter_pkg::*;
#(
    parameter int unsigned N = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    lockable_rr_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = arb_idx_w(N);

    arb_state_t       st, st_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] lock_idx, lock_idx_nxt;

    logic [IDX_W-1:0] start_c;
    logic [N-1:0]     pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic [N-1:0]     lock_oh;
    logic [N-1:0]     gnt_c;
    logic [IDX_W-1:0] gnt_idx_c;
    logic             accepted_c;

    // Fixed priority is round-robin pinned to start 0.
    assign start_c = bus.mode_rr ? ptr : '0;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .vec    (bus.req),
        .start  (start_c),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    always_comb begin
        lock_oh = '0;
        for (int i = 0; i < N; i++) begin
            lock_oh[i] = (lock_idx == IDX_W'(i));
        end
    end

    // While locked only the owner can be granted; a stalled owner yields no grant.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        if (st == ARB_LOCKED) begin
            gnt_c = lock_oh & bus.req;
            if (|gnt_c) gnt_idx_c = lock_idx;
        end else begin
            gnt_c     = pick_oh;
            gnt_idx_c = pick_idx;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.gnt_idx   = gnt_idx_c;
    assign bus.gnt_valid = |gnt_c;
    assign bus.locked    = (st == ARB_LOCKED);
    assign accepted_c    = (|gnt_c) && bus.accept;

    always_comb begin
        st_nxt       = st;
        ptr_nxt      = ptr;
        lock_idx_nxt = lock_idx;
        if (accepted_c) begin
            if (bus.req_last[gnt_idx_c]) begin
                st_nxt  = ARB_IDLE;
                ptr_nxt = (gnt_idx_c == IDX_W'(N - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
            end else begin
                st_nxt       = ARB_LOCKED;
                lock_idx_nxt = gnt_idx_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ARB_IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else begin
            st       <= st_nxt;
            ptr      <= ptr_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.gnt))
        else $error("arbiter invariant: gnt not onehot0");
    a_gnt_valid   : assert property (@(posedge clk) disable iff (!rst_n) bus.gnt_valid == (|bus.gnt))
        else $error("arbiter invariant: gnt_valid inconsistent");
    a_gnt_req     : assert property (@(posedge clk) disable iff (!rst_n) (bus.gnt & ~bus.req) == '0)
        else $error("arbiter invariant: grant without request");
    a_lock_owner  : assert property (@(posedge clk) disable iff (!rst_n)
                                     (st == ARB_LOCKED) |-> ((bus.gnt & ~lock_oh) == '0))
        else $error("arbiter invariant: locked grant to non-owner");
    a_ptr_range   : assert property (@(posedge clk) disable iff (!rst_n) 32'(ptr) < N)
        else $error("arbiter invariant: ptr out of range");
    a_lock_range  : assert property (@(posedge clk) disable iff (!rst_n) 32'(lock_idx) < N)
        else $error("arbiter invariant: lock_idx out of range");

endmodule

// File: tb/tb_lockable_rr_arbiter.sv
// Directed bench for lockable_rr_arbiter with N=4 and hand-computed grants.
module tb_lockable_rr_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    lockable_rr_arbiter_if #(.N(4)) bus ();

    lockable_rr_arbiter #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic mode, input logic [3:0] r, input logic [3:0] l, input logic a);
        @(negedge clk);
        bus.mode_rr  = mode;
        bus.req      = r;
        bus.req_last = l;
        bus.accept   = a;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] gi,
                              input logic lk);
        chk({tag, ".gnt"},       32'(bus.gnt),       32'(g));
        chk({tag, ".gnt_idx"},   32'(bus.gnt_idx),   32'(gi));
        chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(|g));
        chk({tag, ".locked"},    32'(bus.locked),    32'(lk));
    endtask

    initial begin
        logic [3:0] rr_g [6];
        logic [1:0] rr_i [6];
        total = 0;
        bad   = 0;
        rst_n        = 1'b0;
        bus.mode_rr  = 1'b0;
        bus.req      = '0;
        bus.req_last = '0;
        bus.accept   = 1'b0;

        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        expect_out("reset", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        expect_out("post_reset", 4'b0000, 2'd0, 1'b0);

        // Fixed priority never rotates; ptr still advances to 2.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'b1110, 4'b1111, 1'b1);
            expect_out("fixed", 4'b0010, 2'd1, 1'b0);
        end

        // Round-robin from ptr=2 with wrap; ends with ptr=0.
        rr_g = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rr_i = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 4'b1111, 4'b1111, 1'b1);
            expect_out("rr_rotate", rr_g[k], rr_i[k], 1'b0);
        end

        // Three-beat transfer on idx1 while idx3 waits.
        drive(1'b1, 4'b1010, 4'b0000, 1'b1);
        expect_out("lock_beat1", 4'b0010, 2'd1, 1'b0);
        drive(1'b1, 4'b1010, 4'b0000, 1'b1);
        expect_out("lock_beat2", 4'b0010, 2'd1, 1'b1);
        drive(1'b1, 4'b1010, 4'b0010, 1'b1);
        expect_out("lock_beat3", 4'b0010, 2'd1, 1'b1);
        drive(1'b1, 4'b1010, 4'b1111, 1'b1);
        expect_out("after_lock", 4'b1000, 2'd3, 1'b0);

        // Lock on idx2, owner stalls while idx0 requests.
        drive(1'b1, 4'b0100, 4'b0000, 1'b1);
        expect_out("lock2_start", 4'b0100, 2'd2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 4'b0001, 4'b0000, 1'b1);
            expect_out("owner_stall", 4'b0000, 2'd0, 1'b1);
        end
        // Mode change while locked has no effect on the owner's grant.
        drive(1'b0, 4'b0101, 4'b0000, 1'b1);
        expect_out("owner_back", 4'b0100, 2'd2, 1'b1);

        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'b0100, 4'b0000, 1'b0);
            expect_out("no_accept", 4'b0100, 2'd2, 1'b1);
        end

        // Reset mid-transfer drops the lock immediately.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_out("reset_mid", 4'b0100, 2'd2, 1'b0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.req      = 4'b0000;
        bus.req_last = 4'b1111;
        bus.accept   = 1'b1;
        #1;
        expect_out("accept_no_valid", 4'b0000, 2'd0, 1'b0);
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        expect_out("rr_after_reset0", 4'b0001, 2'd0, 1'b0);
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        expect_out("rr_after_reset1", 4'b0010, 2'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
